// File: rtl/sm4_round_key_store.sv
// SM4 key-schedule engine: expands a 128-bit master key into 32 round keys
// (one per cycle) and streams them forward or reversed over valid/ready.
module sm4_round_key_store (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_busy,
  output logic         key_ready,
  input  logic         stream_start,
  input  logic         stream_dec,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_idx,
  output logic         rk_last
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  // S-box entry 0 sits in the top byte, so entry a lives at byte (255 - a) = ~a.
  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [7:0] base;
    ck_word = '0;
    for (int j = 0; j < 4; j++) begin
      base = {1'b0, i, 2'(j)};
      ck_word[31-8*j -: 8] = base * 8'd7;
    end
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [31:0] k0_q, k1_q, k2_q, k3_q;
  logic [31:0] k0_d, k1_d, k2_d, k3_d;
  logic [31:0] store_q [32];
  logic        store_we;
  logic [31:0] rk_new;
  logic [4:0]  rd_idx;

  assign rk_new = k0_q ^ t_prime(k1_q ^ k2_q ^ k3_q ^ ck_word(cnt_q));

  // cnt_q is the expansion index in EXPAND and the handshake count in STREAM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    k0_d     = k0_q;
    k1_d     = k1_q;
    k2_d     = k2_q;
    k3_d     = k3_q;
    store_we = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_load) begin
          state_d = EXPAND;
          cnt_d   = 5'd0;
          k0_d    = key_in[127:96] ^ FK0;
          k1_d    = key_in[95:64]  ^ FK1;
          k2_d    = key_in[63:32]  ^ FK2;
          k3_d    = key_in[31:0]   ^ FK3;
        end else if (state_q == READY && stream_start) begin
          state_d = STREAM;
          cnt_d   = 5'd0;
          dec_d   = stream_dec;
        end
      end
      EXPAND: begin
        store_we = 1'b1;
        k0_d     = k1_q;
        k1_d     = k2_q;
        k2_d     = k3_q;
        k3_d     = rk_new;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = READY;
      end
      STREAM: begin
        // A key transfers on any edge where rk_valid && rk_ready; rk_valid
        // stays high until the transfer of index 31 completes.
        if (rk_ready) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dec_q   <= 1'b0;
      k0_q    <= 32'd0;
      k1_q    <= 32'd0;
      k2_q    <= 32'd0;
      k3_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
    end
  end

  // Contents are only meaningful while key_ready is high, so no reset.
  always_ff @(posedge clk) begin
    if (store_we) store_q[cnt_q] <= rk_new;
  end

  assign rd_idx    = dec_q ? ~cnt_q : cnt_q;
  assign key_busy  = (state_q == EXPAND);
  assign key_ready = (state_q == READY) || (state_q == STREAM);
  assign rk_valid  = (state_q == STREAM);
  assign rk_idx    = rk_valid ? cnt_q : 5'd0;
  assign rk_out    = rk_valid ? store_q[rd_idx] : 32'd0;
  assign rk_last   = rk_valid && (cnt_q == 5'd31);

endmodule
